// File: rtl/arith_seq_unit_if.sv
// Request/response bundle for arith_seq_unit: operands and opcode in, result and status out.
interface arith_seq_unit_if #(
  parameter int WIDTH = 16,
  parameter int IMM_W = 8,
  parameter int SH_W  = 4
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] r_in;
  logic [WIDTH-1:0] m_in;
  logic [WIDTH-1:0] in_port;
  logic [IMM_W-1:0] imm;
  logic [SH_W-1:0]  shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             flag_z;
  logic             flag_c;
  logic             flag_n;
  logic             flag_v;

  modport master (
    output start, op, a_in, r_in, m_in, in_port, imm, shamt,
    input  busy, done, result, result_hi, flag_z, flag_c, flag_n, flag_v
  );

  modport slave (
    input  start, op, a_in, r_in, m_in, in_port, imm, shamt,
    output busy, done, result, result_hi, flag_z, flag_c, flag_n, flag_v
  );
endinterface

// File: rtl/arith_seq_unit.sv
// Registered arithmetic unit: single-cycle ALU ops plus multi-cycle N-bit rotate
// and unsigned shift-add multiply, with Z/C/N/V flag registers.
module arith_seq_unit #(
  parameter int WIDTH = 16,
  parameter int IMM_W = 8,
  parameter int SH_W  = 4
) (
  input logic              clk,
  input logic              rst,
  arith_seq_unit_if.slave  bus
);

  localparam int CNT_W = SH_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ROT, S_MUL} state_e;

  typedef enum logic [3:0] {
    OP_R, OP_M, OP_IMM, OP_AND, OP_OR, OP_ADD, OP_SUB, OP_IN,
    OP_NOT, OP_INC, OP_DEC, OP_SHL1, OP_SHR1, OP_ROR1, OP_ROR, OP_MUL
  } op_e;

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   result_hi_q, result_hi_d;
  logic               z_q, z_d, c_q, c_d, n_q, n_d, v_q, v_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   rot_next;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_e'(bus.op))
      OP_R:    alu_res = bus.r_in;
      OP_M:    alu_res = bus.m_in;
      OP_IMM:  alu_res = WIDTH'(bus.imm);
      OP_AND:  alu_res = bus.a_in & bus.r_in;
      OP_OR:   alu_res = bus.a_in | bus.r_in;
      OP_ADD: begin
        sum     = {1'b0, bus.a_in} + {1'b0, bus.r_in};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (bus.a_in[WIDTH-1] == bus.r_in[WIDTH-1]) && (alu_res[WIDTH-1] != bus.a_in[WIDTH-1]);
      end
      // Wrapped subtraction leaves the borrow in the extra top bit.
      OP_SUB: begin
        sum     = {1'b0, bus.a_in} - {1'b0, bus.r_in};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (bus.a_in[WIDTH-1] != bus.r_in[WIDTH-1]) && (alu_res[WIDTH-1] != bus.a_in[WIDTH-1]);
      end
      OP_IN:   alu_res = bus.in_port;
      OP_NOT:  alu_res = ~bus.a_in;
      OP_INC: begin
        sum     = {1'b0, bus.a_in} + (WIDTH+1)'(1);
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = ~bus.a_in[WIDTH-1] & alu_res[WIDTH-1];
      end
      OP_DEC: begin
        sum     = {1'b0, bus.a_in} - (WIDTH+1)'(1);
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = bus.a_in[WIDTH-1] & ~alu_res[WIDTH-1];
      end
      OP_SHL1: begin
        alu_res = {bus.a_in[WIDTH-2:0], 1'b0};
        alu_c   = bus.a_in[WIDTH-1];
      end
      OP_SHR1: begin
        alu_res = {1'b0, bus.a_in[WIDTH-1:1]};
        alu_c   = bus.a_in[0];
      end
      OP_ROR1: begin
        alu_res = {bus.a_in[0], bus.a_in[WIDTH-1:1]};
        alu_c   = bus.a_in[0];
      end
      OP_ROR:  alu_res = bus.a_in;
      default: alu_res = '0;
    endcase
  end

  assign rot_next = {acc_q[0], acc_q[WIDTH-1:1]};
  assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    z_d         = z_q;
    c_d         = c_q;
    n_d         = n_q;
    v_d         = v_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    prod_d      = prod_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (op_e'(bus.op) == OP_MUL) begin
            state_d = S_MUL;
            busy_d  = 1'b1;
            mcand_d = bus.a_in;
            prod_d  = {{WIDTH{1'b0}}, bus.r_in};
            cnt_d   = CNT_W'(WIDTH);
          end else if (op_e'(bus.op) == OP_ROR && bus.shamt != '0) begin
            state_d = S_ROT;
            busy_d  = 1'b1;
            acc_d   = bus.a_in;
            cnt_d   = CNT_W'(bus.shamt);
          end else begin
            done_d      = 1'b1;
            result_d    = alu_res;
            result_hi_d = '0;
            z_d         = (alu_res == '0);
            n_d         = alu_res[WIDTH-1];
            c_d         = alu_c;
            v_d         = alu_v;
          end
        end
      end
      // Rotation completes on the edge that performs the last 1-bit step.
      S_ROT: begin
        acc_d = rot_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d     = S_IDLE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          result_d    = rot_next;
          result_hi_d = '0;
          z_d         = (rot_next == '0);
          n_d         = rot_next[WIDTH-1];
          c_d         = rot_next[WIDTH-1];
          v_d         = 1'b0;
        end
      end
      S_MUL: begin
        prod_d = mul_next;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d     = S_IDLE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          result_d    = mul_next[WIDTH-1:0];
          result_hi_d = mul_next[2*WIDTH-1:WIDTH];
          z_d         = (mul_next == '0);
          n_d         = mul_next[2*WIDTH-1];
          c_d         = (mul_next[2*WIDTH-1:WIDTH] != '0);
          v_d         = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      n_q         <= 1'b0;
      v_q         <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      prod_q      <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      z_q         <= z_d;
      c_q         <= c_d;
      n_q         <= n_d;
      v_q         <= v_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      prod_q      <= prod_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.flag_z    = z_q;
  assign bus.flag_c    = c_q;
  assign bus.flag_n    = n_q;
  assign bus.flag_v    = v_q;

endmodule

// File: tb/tb_arith_seq_unit.sv
// Directed bench for arith_seq_unit: hand-computed vectors checked with immediate assertions.
module tb_arith_seq_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  arith_seq_unit_if #(.WIDTH(16), .IMM_W(8), .SH_W(4)) bus ();

  arith_seq_unit #(.WIDTH(16), .IMM_W(8), .SH_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge; returns at the falling edge after the accepting edge.
  task automatic go(input logic [3:0] op, input logic [15:0] a, input logic [15:0] r,
                    input logic [7:0] imm, input logic [3:0] sh);
    bus.op    = op;
    bus.a_in  = a;
    bus.r_in  = r;
    bus.imm   = imm;
    bus.shamt = sh;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic flags(input string tag, input logic z, input logic c, input logic n, input logic v);
    check({tag, ".z"}, bus.flag_z, z);
    check({tag, ".c"}, bus.flag_c, c);
    check({tag, ".n"}, bus.flag_n, n);
    check({tag, ".v"}, bus.flag_v, v);
  endtask

  initial begin
    int nbusy;
    int seen;
    bus.start   = 1'b0;
    bus.op      = '0;
    bus.a_in    = '0;
    bus.r_in    = '0;
    bus.m_in    = 16'h5A5A;
    bus.in_port = 16'hC3C3;
    bus.imm     = '0;
    bus.shamt   = '0;
    repeat (3) @(negedge clk);
    check("rst.busy", bus.busy, 1'b0);
    check("rst.done", bus.done, 1'b0);
    check("rst.result", bus.result, 16'h0000);
    flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    go(4'd5, 16'h7FFF, 16'h0001, 8'h00, 4'd0);
    check("add.done", bus.done, 1'b1);
    check("add.busy", bus.busy, 1'b0);
    check("add.result", bus.result, 16'h8000);
    flags("add", 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("add.done_off", bus.done, 1'b0);
    check("add.hold", bus.result, 16'h8000);
    check("add.hold_v", bus.flag_v, 1'b1);

    go(4'd6, 16'h0000, 16'h0001, 8'h00, 4'd0);
    check("sub.result", bus.result, 16'hFFFF);
    flags("sub", 1'b0, 1'b1, 1'b1, 1'b0);
    go(4'd10, 16'h8000, 16'h0000, 8'h00, 4'd0);
    check("dec.result", bus.result, 16'h7FFF);
    flags("dec", 1'b0, 1'b0, 1'b0, 1'b1);
    go(4'd9, 16'hFFFF, 16'h0000, 8'h00, 4'd0);
    check("inc.result", bus.result, 16'h0000);
    flags("inc", 1'b1, 1'b1, 1'b0, 1'b0);
    go(4'd3, 16'hF0F0, 16'h0F0F, 8'h00, 4'd0);
    check("and.result", bus.result, 16'h0000);
    check("and.z", bus.flag_z, 1'b1);
    go(4'd4, 16'hF0F0, 16'h0F0F, 8'h00, 4'd0);
    check("or.result", bus.result, 16'hFFFF);
    go(4'd0, 16'h0000, 16'h1234, 8'h00, 4'd0);
    check("passr.result", bus.result, 16'h1234);
    go(4'd1, 16'h0000, 16'h0000, 8'h00, 4'd0);
    check("passm.result", bus.result, 16'h5A5A);
    go(4'd7, 16'h0000, 16'h0000, 8'h00, 4'd0);
    check("in.result", bus.result, 16'hC3C3);
    go(4'd8, 16'h00FF, 16'h0000, 8'h00, 4'd0);
    check("not.result", bus.result, 16'hFF00);
    check("not.n", bus.flag_n, 1'b1);
    go(4'd11, 16'h8001, 16'h0000, 8'h00, 4'd0);
    check("shl.result", bus.result, 16'h0002);
    check("shl.c", bus.flag_c, 1'b1);
    go(4'd12, 16'h0003, 16'h0000, 8'h00, 4'd0);
    check("shr.result", bus.result, 16'h0001);
    check("shr.c", bus.flag_c, 1'b1);
    go(4'd13, 16'h0001, 16'h0000, 8'h00, 4'd0);
    check("ror1.result", bus.result, 16'h8000);
    flags("ror1", 1'b0, 1'b1, 1'b1, 1'b0);
    go(4'd2, 16'h0000, 16'h0000, 8'hA5, 4'd0);
    check("imm.result", bus.result, 16'h00A5);
    flags("imm", 1'b0, 1'b0, 1'b0, 1'b0);

    // Rotate by 4; operands changed after acceptance must not matter.
    go(4'd14, 16'h0001, 16'h0000, 8'h00, 4'd4);
    bus.a_in  = 16'hFFFF;
    bus.shamt = 4'd9;
    nbusy = 0;
    for (int i = 0; i < 40 && !bus.done; i++) begin
      if (bus.busy) nbusy++;
      @(negedge clk);
    end
    check("ror.done", bus.done, 1'b1);
    check("ror.busy_cycles", nbusy, 4);
    check("ror.busy_at_done", bus.busy, 1'b0);
    check("ror.result", bus.result, 16'h1000);
    flags("ror", 1'b0, 1'b0, 1'b0, 1'b0);
    go(4'd14, 16'h1234, 16'h0000, 8'h00, 4'd0);
    check("ror0.done", bus.done, 1'b1);
    check("ror0.busy", bus.busy, 1'b0);
    check("ror0.result", bus.result, 16'h1234);
    check("ror0.c", bus.flag_c, 1'b0);

    // Multiply with ignored start pulses while busy, then back-to-back ADD.
    go(4'd15, 16'hFFFF, 16'hFFFF, 8'h00, 4'd0);
    bus.op   = 4'd5;
    bus.a_in = 16'h0011;
    bus.r_in = 16'h0022;
    nbusy = 0;
    for (int i = 0; i < 40 && !bus.done; i++) begin
      if (bus.busy) nbusy++;
      bus.start = (i == 3 || i == 8);
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("mul.done", bus.done, 1'b1);
    check("mul.busy_cycles", nbusy, 16);
    check("mul.busy_at_done", bus.busy, 1'b0);
    check("mul.lo", bus.result, 16'h0001);
    check("mul.hi", bus.result_hi, 16'hFFFE);
    flags("mul", 1'b0, 1'b1, 1'b1, 1'b0);
    go(4'd5, 16'h0001, 16'h0002, 8'h00, 4'd0);
    check("b2b.done", bus.done, 1'b1);
    check("b2b.result", bus.result, 16'h0003);
    check("b2b.hi", bus.result_hi, 16'h0000);
    flags("b2b", 1'b0, 1'b0, 1'b0, 1'b0);

    // Async reset in cycle 5 of a multiply; previous result/flags nonzero.
    go(4'd13, 16'h0001, 16'h0000, 8'h00, 4'd0);
    go(4'd15, 16'h0003, 16'h0005, 8'h00, 4'd0);
    repeat (4) @(negedge clk);
    check("mrst.busy_before", bus.busy, 1'b1);
    rst = 1'b1;
    #1;
    check("mrst.busy", bus.busy, 1'b0);
    check("mrst.done", bus.done, 1'b0);
    check("mrst.result", bus.result, 16'h0000);
    check("mrst.hi", bus.result_hi, 16'h0000);
    flags("mrst", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    check("mrst.no_done", seen, 0);
    go(4'd5, 16'h0002, 16'h0003, 8'h00, 4'd0);
    check("mrst.after", bus.result, 16'h0005);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
